// File: rtl/packet_or_accumulator_pkg.sv
// packet_or_accumulator_pkg: shared FSM state type and default sizing for the packet OR reducer.
package packet_or_accumulator_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 8;
    typedef enum logic [0:0] {ST_ACC, ST_HOLD} state_t;
endpackage

// File: rtl/packet_or_accumulator_if.sv
// packet_or_accumulator_if: upstream word stream and downstream per-packet result channel.
interface packet_or_accumulator_if #(
    parameter int WIDTH = packet_or_accumulator_pkg::DEF_WIDTH,
    parameter int CNT_W = packet_or_accumulator_pkg::DEF_CNT_W
);
    logic             up_valid;
    logic             up_ready;
    logic [WIDTH-1:0] up_data;
    logic             up_last;
    logic             down_valid;
    logic             down_ready;
    logic [WIDTH-1:0] down_data;
    logic             down_any;
    logic [CNT_W-1:0] down_count;
    modport master (
        output up_valid, up_data, up_last, down_ready,
        input  up_ready, down_valid, down_data, down_any, down_count
    );
    modport slave (
        input  up_valid, up_data, up_last, down_ready,
        output up_ready, down_valid, down_data, down_any, down_count
    );
endinterface

// File: rtl/packet_or_accumulator_or_word.sv
// or_word: WIDTH-bit bitwise OR built from one 2:1 mux per bit (sel=a, d1=1, d0=b).
module or_word #(
    parameter int WIDTH = packet_or_accumulator_pkg::DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        assign y[g] = a[g] ? 1'b1 : b[g];
    end
endmodule

// File: rtl/packet_or_accumulator.sv
// packet_or_accumulator: ORs all words of a packet and emits one registered result per packet.
// Optional saturating word counter enabled by PACKET_OR_ACCUMULATOR_COUNT_EN.
module packet_or_accumulator
    import packet_or_accumulator_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input logic                    clk,
    input logic                    rst,
    packet_or_accumulator_if.slave bus
);
    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_or;
    logic [WIDTH-1:0] data_q;
    logic             any_q;
    logic             up_fire;
    logic             down_fire;

    or_word #(.WIDTH(WIDTH)) u_or (.a(acc), .b(bus.up_data), .y(acc_or));

    assign bus.up_ready   = state == ST_ACC;
    assign bus.down_valid = state == ST_HOLD;
    assign bus.down_data  = data_q;
    assign bus.down_any   = any_q;
    assign up_fire        = bus.up_valid && bus.up_ready;
    assign down_fire      = bus.down_valid && bus.down_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_ACC;
            acc    <= '0;
            data_q <= '0;
            any_q  <= 1'b0;
        end else begin
            if (up_fire) begin
                acc <= bus.up_last ? '0 : acc_or;
                if (bus.up_last) begin
                    data_q <= acc_or;
                    any_q  <= |acc_or;
                    state  <= ST_HOLD;
                end
            end
            if (down_fire) state <= ST_ACC;
        end
    end

`ifdef PACKET_OR_ACCUMULATOR_COUNT_EN
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] count_q;

    // Saturate rather than wrap so oversized packets report the ceiling.
    assign cnt_nxt        = &cnt ? cnt : cnt + 1'b1;
    assign bus.down_count = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            count_q <= '0;
        end else if (up_fire) begin
            cnt <= bus.up_last ? '0 : cnt_nxt;
            if (bus.up_last) count_q <= cnt_nxt;
        end
    end
`else
    assign bus.down_count = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_packet_or_accumulator.sv
// tb_packet_or_accumulator: directed stimulus with a scoreboard of expected per-packet results.
module tb_packet_or_accumulator;
    localparam int W  = 8;
    localparam int CW = 2;

    typedef struct {
        logic [W-1:0]  d;
        logic          a;
        logic [CW-1:0] c;
    } res_t;

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    res_t   q[$];
    logic [W-1:0] m_acc = '0;
    int     m_n     = 0;
    int     n_tests = 0;
    int     n_fail  = 0;

    always #5 clk = ~clk;

    packet_or_accumulator_if #(.WIDTH(W), .CNT_W(CW)) bus ();
    packet_or_accumulator #(.WIDTH(W), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic logic [CW-1:0] exp_count(input int n);
`ifdef PACKET_OR_ACCUMULATOR_COUNT_EN
        return (n > 3) ? CW'(3) : CW'(n);
`else
        return CW'(0);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_word(input logic [W-1:0] d, input logic last);
        bus.up_valid = 1'b1;
        bus.up_data  = d;
        bus.up_last  = last;
        @(posedge clk);
        #1;
        bus.up_valid = 1'b0;
        m_acc |= d;
        m_n++;
        if (last) begin
            q.push_back('{d: m_acc, a: |m_acc, c: exp_count(m_n)});
            m_acc = '0;
            m_n   = 0;
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.up_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        m_acc = '0;
        m_n   = 0;
    endtask

    task automatic check_result(input string tag);
        res_t e;
        @(negedge clk);
        for (int k = 0; k < 20 && bus.down_valid !== 1'b1; k++) @(negedge clk);
        chk({tag, "_valid"}, 32'(bus.down_valid), 32'd1);
        if (q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = q.pop_front();
        chk({tag, "_data"}, 32'(bus.down_data), 32'(e.d));
        chk({tag, "_any"}, 32'(bus.down_any), 32'(e.a));
        chk({tag, "_count"}, 32'(bus.down_count), 32'(e.c));
        chk({tag, "_up_ready_hold"}, 32'(bus.up_ready), 32'd0);
        bus.down_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.down_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(bus.down_valid), 32'd0);
        chk({tag, "_up_ready_back"}, 32'(bus.up_ready), 32'd1);
    endtask

    initial begin
        bus.up_valid   = 1'b0;
        bus.up_data    = '0;
        bus.up_last    = 1'b0;
        bus.down_ready = 1'b0;
        do_reset();
        @(negedge clk);
        chk("rst_down_valid", 32'(bus.down_valid), 32'd0);
        chk("rst_up_ready", 32'(bus.up_ready), 32'd1);
        chk("rst_down_data", 32'(bus.down_data), 32'd0);
        chk("rst_down_any", 32'(bus.down_any), 32'd0);
        chk("rst_down_count", 32'(bus.down_count), 32'd0);
        @(posedge clk);
        #1;
        // Single-word packet; result must appear the cycle after the transfer.
        drive_word(8'h05, 1'b1);
        chk("t1_latency", 32'(bus.down_valid), 32'd1);
        check_result("t1");
        drive_word(8'h01, 1'b0);
        drive_word(8'h10, 1'b0);
        drive_word(8'h80, 1'b1);
        check_result("t2");
        bus.down_ready = 1'b1;
        drive_word(8'h00, 1'b0);
        @(posedge clk);
        #1;
        drive_word(8'h00, 1'b1);
        check_result("t3");
        // Held result; upstream offers a word that must not be consumed.
        drive_word(8'h22, 1'b1);
        bus.up_valid = 1'b1;
        bus.up_data  = 8'hFF;
        bus.up_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", 32'(bus.down_valid), 32'd1);
            chk("t4_hold_data", 32'(bus.down_data), 32'h22);
            chk("t4_hold_up_ready", 32'(bus.up_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.up_valid = 1'b0;
        check_result("t4");
        drive_word(8'h40, 1'b1);
        check_result("t4_next");
        drive_word(8'hF0, 1'b0);
        drive_word(8'h0F, 1'b0);
        do_reset();
        drive_word(8'h02, 1'b1);
        check_result("t5");
        drive_word(8'h33, 1'b1);
        do_reset();
        @(negedge clk);
        chk("t5_rst_hold_valid", 32'(bus.down_valid), 32'd0);
        chk("t5_rst_hold_data", 32'(bus.down_data), 32'd0);
        @(posedge clk);
        #1;
        drive_word(8'h01, 1'b0);
        drive_word(8'h02, 1'b0);
        drive_word(8'h04, 1'b0);
        drive_word(8'h08, 1'b0);
        drive_word(8'h10, 1'b1);
        check_result("t6");
        chk("sb_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
